// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants, waveform encodings and FSM state type
package synth_pkg;

    localparam int NOTE_W     = 7;
    localparam int FREQ_W_DEF = 20;
    localparam int AGE_W_DEF  = 8;

    localparam logic [1:0] WAVE_0 = 2'd0;
    localparam logic [1:0] WAVE_1 = 2'd1;
    localparam logic [1:0] WAVE_2 = 2'd2;
    localparam logic [1:0] WAVE_3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ALLOC  = 2'd2,
        UPDATE = 2'd3
    } state_t;

endpackage

// File: rtl/note_freq_rom.sv
// rtl/note_freq_rom.sv - 128-entry note number to integer-Hz table, 1-cycle registered read
//
// Ports:
//   clk   system clock
//   note  MIDI note number 0..127
//   freq  round(440 * 2^((note-69)/12)) Hz, valid the cycle after note is presented
//
// The table is generated from the top octave (notes 120..131) held with 8
// fractional bits; lower octaves are that value shifted right with
// round-half-up, which reproduces the rounded formula for every note 0..127.
module note_freq_rom
    import synth_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic [NOTE_W-1:0] note,
    output logic [FREQ_W-1:0] freq
);

    logic [6:0]  octave;
    logic [3:0]  semitone;
    logic [21:0] top_fixed;
    logic [4:0]  shamt;
    logic [22:0] rounded;
    logic [FREQ_W-1:0] freq_c;

    // Frequency of note 120+r in Hz, scaled by 256.
    function automatic logic [21:0] top_octave(input logic [3:0] r);
        case (r)
            4'd0:    return 22'd2143237;
            4'd1:    return 22'd2270680;
            4'd2:    return 22'd2405702;
            4'd3:    return 22'd2548752;
            4'd4:    return 22'd2700309;
            4'd5:    return 22'd2860878;
            4'd6:    return 22'd3030994;
            4'd7:    return 22'd3211227;
            4'd8:    return 22'd3402176;
            4'd9:    return 22'd3604480;
            4'd10:   return 22'd3818813;
            4'd11:   return 22'd4045892;
            default: return 22'd0;
        endcase
    endfunction

    always_comb begin
        octave    = note / 7'd12;
        semitone  = 4'((note % 7'd12));
        top_fixed = top_octave(semitone);
        // 8 fractional bits plus one shift per octave below the top one
        shamt     = 5'd18 - 5'(octave);
        rounded   = ({1'b0, top_fixed} + (23'd1 << (shamt - 5'd1))) >> shamt;
        freq_c    = FREQ_W'(rounded);
    end

    always_ff @(posedge clk) begin
        freq <= freq_c;
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note-to-oscillator voice allocator
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   note_valid/note_ready  event handshake, accept on valid & ready
//   note_on, note_num      event type (1=on) and MIDI note number
//   wave_sel               waveform select applied on note-on
//   freq_out               per-voice frequency, voice 0 in LSBs
//   ctrl_out               per-voice waveform select, voice 0 in LSBs
//   osc_reset              one-cycle phase-reset pulse to the retargeted voice
//   gate                   voice currently sounding
//   dropped                one-cycle pulse when a note-on found no voice
//   busy                   event in progress (!note_ready)
//
// Build option: VOICE_STEAL_EN - when defined, a note-on with all voices
// sounding steals the oldest voice; otherwise the note is dropped and the
// age counters are not built.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = FREQ_W_DEF
`ifdef VOICE_STEAL_EN
    ,
    parameter int AGE_W      = AGE_W_DEF
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         note_valid,
    output logic                         note_ready,
    input  logic                         note_on,
    input  logic [NOTE_W-1:0]            note_num,
    input  logic [1:0]                   wave_sel,
    output logic [NUM_VOICES*FREQ_W-1:0] freq_out,
    output logic [NUM_VOICES*2-1:0]      ctrl_out,
    output logic [NUM_VOICES-1:0]        osc_reset,
    output logic [NUM_VOICES-1:0]        gate,
    output logic                         dropped,
    output logic                         busy
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t state;

    logic [NOTE_W-1:0] cap_note;
    logic              cap_on;
    logic [1:0]        cap_wave;
    logic [FREQ_W-1:0] rom_freq;

    logic [NUM_VOICES-1:0][FREQ_W-1:0] v_freq;
    logic [NUM_VOICES-1:0][1:0]        v_ctrl;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] v_note;

    logic [VW-1:0] tgt_idx_c;
    logic          tgt_hit_c;
    logic [VW-1:0] tgt_idx;
    logic          tgt_hit;

`ifdef VOICE_STEAL_EN
    logic [NUM_VOICES-1:0][AGE_W-1:0] v_age;
    logic [AGE_W-1:0]                 best_age;
`endif

    // Address comes from the captured note, so the read is valid after E1
    // and stays stable until the voice write at E3.
    note_freq_rom #(
        .FREQ_W (FREQ_W)
    ) u_rom (
        .clk  (clk),
        .note (cap_note),
        .freq (rom_freq)
    );

    assign note_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign freq_out   = v_freq;
    assign ctrl_out   = v_ctrl;

    // Target search: matching sounding voice, then lowest free voice,
    // then (when stealing) the oldest voice with ties to the lowest index.
    always_comb begin
        tgt_hit_c = 1'b0;
        tgt_idx_c = '0;
`ifdef VOICE_STEAL_EN
        best_age  = '0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!tgt_hit_c && gate[i] && (v_note[i] == cap_note)) begin
                tgt_hit_c = 1'b1;
                tgt_idx_c = VW'(i);
            end
        end
        if (cap_on && !tgt_hit_c) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!tgt_hit_c && !gate[i]) begin
                    tgt_hit_c = 1'b1;
                    tgt_idx_c = VW'(i);
                end
            end
`ifdef VOICE_STEAL_EN
            if (!tgt_hit_c) begin
                tgt_hit_c = 1'b1;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (v_age[i] > best_age) begin
                        best_age  = v_age[i];
                        tgt_idx_c = VW'(i);
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cap_note  <= '0;
            cap_on    <= 1'b0;
            cap_wave  <= WAVE_0;
            tgt_idx   <= '0;
            tgt_hit   <= 1'b0;
            v_freq    <= '0;
            v_ctrl    <= '0;
            v_note    <= '0;
            gate      <= '0;
            osc_reset <= '0;
            dropped   <= 1'b0;
`ifdef VOICE_STEAL_EN
            v_age     <= '0;
`endif
        end else begin
            osc_reset <= '0;
            dropped   <= 1'b0;
            case (state)
                IDLE: begin
                    if (note_valid) begin
                        cap_note <= note_num;
                        cap_on   <= note_on;
                        cap_wave <= wave_sel;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= ALLOC;
                end
                ALLOC: begin
                    tgt_idx <= tgt_idx_c;
                    tgt_hit <= tgt_hit_c;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    state <= IDLE;
                    if (cap_on) begin
                        if (tgt_hit) begin
                            v_freq[tgt_idx]    <= rom_freq;
                            v_ctrl[tgt_idx]    <= cap_wave;
                            v_note[tgt_idx]    <= cap_note;
                            gate[tgt_idx]      <= 1'b1;
                            osc_reset[tgt_idx] <= 1'b1;
`ifdef VOICE_STEAL_EN
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (VW'(i) == tgt_idx) begin
                                    v_age[i] <= '0;
                                end else if (gate[i] && (v_age[i] != {AGE_W{1'b1}})) begin
                                    v_age[i] <= v_age[i] + 1'b1;
                                end
                            end
`endif
                        end else begin
                            dropped <= 1'b1;
                        end
                    end else if (tgt_hit) begin
                        gate[tgt_idx] <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator with a note-level reference model
module tb_voice_allocator;

    localparam int NV     = 4;
    localparam int FW     = 20;
    localparam int AGEMAX = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic            note_valid;
    logic            note_ready;
    logic            note_on;
    logic [6:0]      note_num;
    logic [1:0]      wave_sel;
    logic [NV*FW-1:0] freq_out;
    logic [NV*2-1:0] ctrl_out;
    logic [NV-1:0]   osc_reset;
    logic [NV-1:0]   gate;
    logic            dropped;
    logic            busy;

    voice_allocator #(.NUM_VOICES(NV), .FREQ_W(FW)) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_on    (note_on),
        .note_num   (note_num),
        .wave_sel   (wave_sel),
        .freq_out   (freq_out),
        .ctrl_out   (ctrl_out),
        .osc_reset  (osc_reset),
        .gate       (gate),
        .dropped    (dropped),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV*FW-1:0] freq;
        logic [NV*2-1:0]  ctrl;
        logic [NV-1:0]    gate;
        logic [NV-1:0]    oscr;
        logic             drop;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    int m_gate[NV];
    int m_note[NV];
    int m_freq[NV];
    int m_ctrl[NV];
    int m_age[NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int ref_freq(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        return $rtoi(f + 0.5);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_freq[i] = 0; m_ctrl[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_event(input bit on, input int n, input int w);
        exp_t e;
        int tgt;
        int best;
        tgt = -1;
        e.oscr = '0;
        e.drop = 1'b0;
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && m_gate[i] == 1 && m_note[i] == n) tgt = i;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_gate[i] == 0) tgt = i;
            if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
                best = -1;
                for (int i = 0; i < NV; i++)
                    if (m_age[i] > best) begin best = m_age[i]; tgt = i; end
`else
                e.drop = 1'b1;
`endif
            end
            if (tgt >= 0) begin
                for (int i = 0; i < NV; i++)
                    if (i != tgt && m_gate[i] == 1 && m_age[i] < AGEMAX) m_age[i]++;
                m_age[tgt]  = 0;
                m_gate[tgt] = 1;
                m_note[tgt] = n;
                m_freq[tgt] = ref_freq(n);
                m_ctrl[tgt] = w;
                e.oscr[tgt] = 1'b1;
            end
        end else if (tgt >= 0) begin
            m_gate[tgt] = 0;
        end
        for (int i = 0; i < NV; i++) begin
            e.freq[i*FW +: FW] = FW'(m_freq[i]);
            e.ctrl[i*2 +: 2]   = 2'(m_ctrl[i]);
            e.gate[i]          = (m_gate[i] == 1);
        end
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation in the first idle cycle after each event.
    int  busy_cnt  = 0;
    bit  prev_busy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b0) begin
            busy_cnt  = 0;
            prev_busy = 0;
        end else begin
            chk("osc_reset_onehot", 128'($countones(osc_reset) <= 1), 128'(1));
            if (busy) begin
                busy_cnt++;
                chk("ready_low_while_busy", 128'(note_ready), 128'(0));
                chk("pulse_while_busy", 128'({osc_reset, dropped}), 128'(0));
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", 128'(busy_cnt), 128'(3));
                    chk("freq_out", 128'(freq_out), 128'(e.freq));
                    chk("ctrl_out", 128'(ctrl_out), 128'(e.ctrl));
                    chk("gate", 128'(gate), 128'(e.gate));
                    chk("osc_reset", 128'(osc_reset), 128'(e.oscr));
                    chk("dropped", 128'(dropped), 128'(e.drop));
                end
                busy_cnt = 0;
            end else begin
                chk("idle_no_pulse", 128'({osc_reset, dropped}), 128'(0));
            end
            prev_busy = busy;
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!note_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!note_ready) chk("ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic send(input bit on, input int n, input int w);
        wait_ready();
        note_valid = 1'b1;
        note_on    = on;
        note_num   = 7'(n);
        wave_sel   = 2'(w);
        model_event(on, n, w);
        @(posedge clk);
        #1 note_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_freq"}, 128'(freq_out), 128'(0));
        chk({tag, "_ctrl"}, 128'(ctrl_out), 128'(0));
        chk({tag, "_gate"}, 128'(gate), 128'(0));
        chk({tag, "_oscr"}, 128'(osc_reset), 128'(0));
        chk({tag, "_drop"}, 128'(dropped), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_ready"}, 128'(note_ready), 128'(1));
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        note_valid = 1'b0;
        note_on    = 1'b0;
        note_num   = '0;
        wave_sel   = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;

        send(1, 69, 2);
        send(0, 69, 0);
        send(1, 60, 0);
        send(1, 62, 1);
        send(1, 64, 2);
        send(1, 65, 3);
        send(1, 67, 0);
        send(0, 62, 0);
        send(1, 72, 1);
        send(1, 64, 2);
        send(0, 100, 0);

        // Reset while the event sits in LOOKUP: nothing may be written.
        wait_ready();
        note_valid = 1'b1;
        note_on    = 1'b1;
        note_num   = 7'd50;
        wave_sel   = 2'd3;
        @(posedge clk);
        #1 reset = 1'b1;
        note_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk_reset_state("midreset");
        @(negedge clk);
        reset = 1'b0;
        send(1, 81, 1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                send($urandom_range(0, 1) == 1, int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
            else
                send($urandom_range(0, 99) < 65, 58 + int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
